// File: rtl/imem_access_ctrl.sv
// rtl/imem_access_ctrl.sv - word-to-byte sequencer and fetch/loader arbiter for the instruction memory (optional IMEM_ALIGN_CHK_EN)
module imem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [31:0]       f_addr,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    input  logic [3:0]        l_be,
    output logic              l_done,
    output logic              l_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, RD_BEAT, RD_DRAIN, RD_RESP, WR_BEAT, WR_RESP
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  beat;
    logic [31:0] wbuf;
    logic [3:0]  be_r;
    logic [23:0] rbuf;
    logic        err_r;
    logic        misalign;

    // The loader has priority, so the alignment check looks at whichever address wins
`ifdef IMEM_ALIGN_CHK_EN
    assign misalign = l_valid ? (l_addr[1:0] != 2'b00) : (f_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, f_addr[31:ADDR_W], l_addr[31:ADDR_W]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        f_ready  = 1'b0;
        l_ready  = 1'b0;
        f_rvalid = 1'b0;
        l_done   = 1'b0;
        f_err    = 1'b0;
        l_err    = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE: begin
                l_ready = resetn & l_valid;
                f_ready = resetn & f_valid & ~l_valid;
                if (l_valid)      state_nx = misalign ? WR_RESP : WR_BEAT;
                else if (f_valid) state_nx = misalign ? RD_RESP : RD_BEAT;
            end
            RD_BEAT: begin
                mem_en = 1'b1;
                if (beat == 2'd3) state_nx = RD_DRAIN;
            end
            RD_DRAIN: state_nx = RD_RESP;
            RD_RESP: begin
                f_rvalid = 1'b1;
                f_err    = err_r;
                state_nx = IDLE;
            end
            WR_BEAT: begin
                mem_en = 1'b1;
                mem_we = be_r[beat];
                if (beat == 2'd3) state_nx = WR_RESP;
            end
            WR_RESP: begin
                l_done   = 1'b1;
                l_err    = err_r;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat      <= 2'd0;
            wbuf      <= 32'd0;
            be_r      <= 4'd0;
            rbuf      <= 24'd0;
            err_r     <= 1'b0;
            f_rdata   <= 32'd0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= 2'd0;
                    if (l_ready) begin
                        wbuf  <= l_wdata;
                        be_r  <= l_be;
                        err_r <= misalign;
                        if (!misalign) begin
                            mem_addr  <= l_addr[ADDR_W-1:0];
                            mem_wdata <= l_wdata[7:0];
                        end
                    end else if (f_ready) begin
                        err_r <= misalign;
                        if (misalign) f_rdata  <= 32'd0;
                        else          mem_addr <= f_addr[ADDR_W-1:0];
                    end
                end
                RD_BEAT: begin
                    beat <= beat + 2'd1;
                    if (beat != 2'd3) mem_addr <= mem_addr + 1'b1;
                    // Read data lags its beat by one cycle; bytes 0..2 shift in from the top
                    if (beat != 2'd0) rbuf <= {mem_rdata, rbuf[23:8]};
                end
                RD_DRAIN: f_rdata <= {mem_rdata, rbuf};
                WR_BEAT: begin
                    beat <= beat + 2'd1;
                    if (beat != 2'd3) begin
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= wbuf[15:8];
                        wbuf      <= {8'd0, wbuf[31:8]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// tb/tb_imem_access_ctrl.sv - directed self-checking bench for imem_access_ctrl
module tb_imem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        f_valid = 1'b0;
    logic        f_ready;
    logic [31:0] f_addr = 32'd0;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        l_valid = 1'b0;
    logic        l_ready;
    logic [31:0] l_addr = 32'd0;
    logic [31:0] l_wdata = 32'd0;
    logic [3:0]  l_be = 4'd0;
    logic        l_done;
    logic        l_err;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:1023];

    imem_access_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .resetn(resetn),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_be(l_be), .l_done(l_done), .l_err(l_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        l_valid = 1'b1; l_addr = a; l_wdata = d; l_be = be;
        #1;
        chk("wr_l_ready", 32'(l_ready), 32'd1);
        tick();
        l_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("wr_mem_en", 32'(mem_en), 32'd1);
            chk("wr_mem_we", 32'(mem_we), 32'(be[k]));
            chk("wr_mem_addr", 32'(mem_addr), 32'(10'(a + 32'(k))));
            chk("wr_mem_wdata", 32'(mem_wdata), 32'(d[8*k +: 8]));
            tick();
        end
        chk("wr_l_done", 32'(l_done), 32'd1);
        chk("wr_l_err", 32'(l_err), 32'd0);
        chk("wr_no_rvalid", 32'(f_rvalid), 32'd0);
        tick();
        chk("wr_l_done_end", 32'(l_done), 32'd0);
    endtask

    task automatic rd_body(input logic [31:0] a, input logic [31:0] exp);
        for (int k = 0; k < 4; k++) begin
            chk("rd_mem_en", 32'(mem_en), 32'd1);
            chk("rd_mem_we", 32'(mem_we), 32'd0);
            chk("rd_mem_addr", 32'(mem_addr), 32'(10'(a + 32'(k))));
            tick();
        end
        chk("rd_drain_en", 32'(mem_en), 32'd0);
        chk("rd_drain_addr_hold", 32'(mem_addr), 32'(10'(a + 32'd3)));
        chk("rd_drain_rvalid", 32'(f_rvalid), 32'd0);
        tick();
        chk("rd_rvalid", 32'(f_rvalid), 32'd1);
        chk("rd_rdata", f_rdata, exp);
        chk("rd_err", 32'(f_err), 32'd0);
        chk("rd_no_done", 32'(l_done), 32'd0);
        tick();
        chk("rd_rvalid_end", 32'(f_rvalid), 32'd0);
        chk("rd_rdata_hold", f_rdata, exp);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        f_valid = 1'b1; f_addr = a;
        #1;
        chk("rd_f_ready", 32'(f_ready), 32'd1);
        tick();
        f_valid = 1'b0;
        rd_body(a, exp);
    endtask

    initial begin
        f_valid = 1'b1;
        tick(); tick();
        chk("rst_state_f_ready", 32'(f_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst_l_done", 32'(l_done), 32'd0);
        f_valid = 1'b0;
        resetn = 1'b1;
        tick();

        wr(32'h100, 32'h93500013, 4'b1111);
        wr(32'h104, 32'h04030201, 4'b1111);
        wr(32'h200, 32'h44332211, 4'b1111);
        wr(32'h3FC, 32'hBBAA0000, 4'b1111);
        wr(32'h000, 32'h0000DDCC, 4'b1111);

        fetch(32'h100, 32'h93500013);

        wr(32'h200, 32'hDEADBEEF, 4'b0101);
        fetch(32'h200, 32'h44AD22EF);

        wr(32'h104, 32'hCAFEF00D, 4'b0000);
        fetch(32'hFFFF0104, 32'h04030201);

        fetch(32'h3FE, 32'hDDCCBBAA);

        // simultaneous requests: loader first, fetch the cycle after l_done
        f_valid = 1'b1; f_addr = 32'h100;
        l_valid = 1'b1; l_addr = 32'h300; l_wdata = 32'h01020304; l_be = 4'b1111;
        #1;
        chk("arb_l_ready", 32'(l_ready), 32'd1);
        chk("arb_f_ready", 32'(f_ready), 32'd0);
        tick();
        l_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("arb_busy_f_ready", 32'(f_ready), 32'd0);
            chk("arb_mem_we", 32'(mem_we), 32'd1);
            tick();
        end
        chk("arb_l_done", 32'(l_done), 32'd1);
        chk("arb_no_rvalid", 32'(f_rvalid), 32'd0);
        chk("arb_done_f_ready", 32'(f_ready), 32'd0);
        tick();
        chk("arb_f_ready_after", 32'(f_ready), 32'd1);
        chk("arb_l_done_end", 32'(l_done), 32'd0);
        tick();
        f_valid = 1'b0;
        rd_body(32'h100, 32'h93500013);

`ifdef IMEM_ALIGN_CHK_EN
        f_valid = 1'b1; f_addr = 32'h101;
        #1;
        chk("mis_f_ready", 32'(f_ready), 32'd1);
        tick();
        f_valid = 1'b0;
        chk("mis_mem_en", 32'(mem_en), 32'd0);
        chk("mis_rvalid", 32'(f_rvalid), 32'd1);
        chk("mis_f_err", 32'(f_err), 32'd1);
        chk("mis_rdata", f_rdata, 32'd0);
        tick();
        chk("mis_rvalid_end", 32'(f_rvalid), 32'd0);
        l_valid = 1'b1; l_addr = 32'h202; l_wdata = 32'h12345678; l_be = 4'b1111;
        #1;
        tick();
        l_valid = 1'b0;
        chk("mis_wr_mem_en", 32'(mem_en), 32'd0);
        chk("mis_l_done", 32'(l_done), 32'd1);
        chk("mis_l_err", 32'(l_err), 32'd1);
        tick();
        fetch(32'h200, 32'h44AD22EF);
`else
        fetch(32'h101, 32'h01935000);
`endif

        // reset in cycle 3 of a write: beats 0 and 1 already landed
        l_valid = 1'b1; l_addr = 32'h300; l_wdata = 32'hA5A5A5A5; l_be = 4'b1111;
        #1;
        tick();
        l_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_rst_f_rdata", f_rdata, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_no_done", 32'(l_done), 32'd0);
        end
        resetn = 1'b1;
        #1;
        f_valid = 1'b1; f_addr = 32'h300;
        #1;
        chk("post_rst_f_ready", 32'(f_ready), 32'd1);
        f_valid = 1'b0;
        #1;
        chk("post_rst_f_ready_low", 32'(f_ready), 32'd0);
        tick();
        chk("post_rst_l_done", 32'(l_done), 32'd0);
        fetch(32'h300, 32'h0102A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequencing controller for the byte-wide, byte-addressable instruction memory.
- Turns 32-bit word requests into four single-byte memory beats and arbitrates between two requesters: the fetch unit (word reads) and the program loader (word writes with byte enables).
- Sits between the core's fetch stage / boot loader and the memory array; owns the memory's address, enable and write strobes.

Parameters:
- ADDR_W, 10, byte-address width of the memory (1024 bytes).

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- f_valid  in  1  fetch read request
- f_ready  out  1  fetch request accepted this cycle
- f_addr  in  32  fetch byte address
- f_rvalid  out  1  one-cycle read-response pulse
- f_rdata  out  32  read word, little-endian
- f_err  out  1  error qualifier on f_rvalid
- l_valid  in  1  loader write request
- l_ready  out  1  loader request accepted this cycle
- l_addr  in  32  loader byte address
- l_wdata  in  32  write word, little-endian
- l_be  in  4  byte enables; bit k covers l_wdata[8k+7:8k]
- l_done  out  1  one-cycle write-complete pulse
- l_err  out  1  error qualifier on l_done
- mem_en  out  1  memory beat enable
- mem_we  out  1  memory byte write strobe
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte, valid the cycle after a read beat

Behaviour:
- Reset (asynchronous, resetn=0) clears everything immediately:
  - state=IDLE
  - f_ready, l_ready, f_rvalid, l_done, f_err, l_err, mem_en, mem_we = 0
  - f_rdata=0, mem_addr=0, mem_wdata=0
- Reset mid-transaction abandons the transaction: no response pulse, no further beats. Memory bytes already written stay written.
- States: IDLE, RD_BEAT, RD_DRAIN, RD_RESP, WR_BEAT, WR_RESP.
- f_ready and l_ready are combinational and high only in IDLE.
- Arbitration in IDLE: l_valid=1 sets l_ready=1 and f_ready=0 (loader has fixed priority). Otherwise f_ready=f_valid.
- A request is accepted in the cycle its valid and ready are both high (cycle 0). Address and data are captured at that edge.
- Requesters must hold valid, addr, wdata and be stable until accepted. Ready never depends on registered history beyond state.
- Read sequence (accept in cycle 0, state RD_BEAT):
  - Cycles 1-4: mem_en=1, mem_we=0, mem_addr=base+k for k=0..3.
  - Cycles 2-5: mem_rdata is captured into byte k of the data register.
  - Cycle 5 is RD_DRAIN (mem_en=0).
  - Cycle 6 is RD_RESP: f_rvalid=1, f_rdata holds the assembled word.
  - IDLE again at cycle 7.
- Write sequence (accept in cycle 0, state WR_BEAT):
  - Cycles 1-4: mem_en=1, mem_addr=base+k, mem_wdata=l_wdata byte k, mem_we=l_be[k].
  - Cycle 5 is WR_RESP: l_done=1.
  - IDLE again at cycle 6.
  - l_be=0000 still runs all four beats with mem_we=0.
- Addressing: base=addr[ADDR_W-1:0]; upper address bits are ignored. base+k wraps modulo 2^ADDR_W, so with ADDR_W=10, address 0x3FE touches bytes 0x3FE, 0x3FF, 0x000, 0x001.
- Outputs:
  - f_rdata keeps its last value outside RD_RESP.
  - mem_addr and mem_wdata hold their values when mem_en=0.
  - f_rvalid and l_done are never high in the same cycle.
- No response backpressure: response pulses last exactly one cycle.
- A request asserted during a busy transaction waits. If both requesters are pending when IDLE is re-entered, the loader wins again.

Optional Feature:
- Macro: IMEM_ALIGN_CHK_EN.
- Defined:
  - An accepted request with addr[1:0]!=0 issues no memory beats.
  - The FSM goes directly to the response state in cycle 1, i.e. f_rvalid=1 with f_err=1 and f_rdata=0, or l_done=1 with l_err=1.
  - Aligned requests behave as above with err=0.
- Undefined:
  - f_err and l_err are tied to 0.
  - Misaligned addresses run normally using byte-wise wrap addressing.

Test Plan:
- Preload bytes 0x100..0x103 = 13,00,50,93; fetch f_addr=0x100 -> f_ready in cycle 0; mem_addr 0x100..0x103 in cycles 1-4; f_rvalid in cycle 6 with f_rdata=0x93500013, f_err=0.
- Loader l_addr=0x200, l_wdata=0xDEADBEEF, l_be=0101 -> mem_we only on 0x200 (EF) and 0x202 (AD); l_done in cycle 5. A subsequent fetch of 0x200 returns the preloaded bytes replaced only at 0x200 and 0x202.
- f_valid and l_valid raised in the same cycle -> l_ready=1, f_ready=0. Fetch is accepted in the cycle after l_done. l_done and f_rvalid never coincide.
- Fetch f_addr=0x3FE -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001. f_addr=0xFFFF0104 reads the same bytes as 0x104.
- resetn pulled low in cycle 3 of a write -> all outputs 0 immediately; no l_done; after release f_ready follows f_valid in IDLE.
- With IMEM_ALIGN_CHK_EN, fetch 0x101 -> no mem_en; f_rvalid=1, f_err=1, f_rdata=0 in cycle 1. Without the macro, the same request reads bytes 0x101..0x104.
